// File: rtl/ifq_pkg.sv
// Shared types and default sizing for the instruction fetch queue.
// An entry pairs a fetched instruction word with the PC it was fetched from.
package ifq_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] inst;
        logic [XLEN_DEFAULT-1:0] pc;
    } ifq_entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side push and decode-side pop signals of the instruction fetch queue.
// The master drives fetch data and consumer handshakes; the slave is the queue.
interface inst_fetch_queue_if
    import ifq_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) ();

    logic [XLEN-1:0]               pc;
    logic [XLEN-1:0]               mem_rd;
    logic                          push_valid;
    logic                          push_ready;
    logic                          flush;
    logic [XLEN-1:0]               inst;
    logic [XLEN-1:0]               pc_old;
    logic                          inst_valid;
    logic                          inst_ready;
    logic [count_width(DEPTH)-1:0] count;

    modport master (
        output pc, mem_rd, push_valid, flush, inst_ready,
        input  push_ready, inst, pc_old, inst_valid, count
    );

    modport slave (
        input  pc, mem_rd, push_valid, flush, inst_ready,
        output push_ready, inst, pc_old, inst_valid, count
    );

endinterface

// File: rtl/inst_fetch_queue.sv
// FIFO of {inst, pc} pairs between fetch and decode with flush on redirect.
// Occupancy lives in a counter; pointers only address storage.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Entry width comes from the package, so XLEN must stay at its default.
    ifq_entry_t    mem_reg [DEPTH];

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          not_empty;
    logic          push_ready;
    logic          do_push;
    logic          do_pop;
    ifq_entry_t    head;

    assign not_empty  = (count_reg != '0);
    // At full a same-cycle pop frees the slot being written.
    assign push_ready = (count_reg < FULL_COUNT) || bus.inst_ready;
    assign do_push    = bus.push_valid && push_ready && !bus.flush;
    assign do_pop     = not_empty && bus.inst_ready && !bus.flush;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (bus.flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
            if (do_push && !do_pop)      count_next = count_reg + CW'(1);
            else if (do_pop && !do_push) count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is never cleared; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_reg[wr_ptr_reg] <= '{inst: bus.mem_rd, pc: bus.pc};
        end
    end

    assign head           = mem_reg[rd_ptr_reg];
    assign bus.inst       = not_empty ? head.inst : '0;
    assign bus.pc_old     = not_empty ? head.pc   : '0;
    assign bus.inst_valid = not_empty;
    assign bus.push_ready = push_ready;
    assign bus.count      = count_reg;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: fill, pop-through, wrap, flush, reset, empty push.
module tb_inst_fetch_queue;
    import ifq_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    inst_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    inst_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] inst_tab [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", bus.inst); end
        checks++; if (bus.pc_old !== 32'h0) begin errors++; $display("FAIL reset_pc_old: got %h expected 0", bus.pc_old); end
        checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b expected 1", bus.push_ready); end
        rst_n = 1'b1;
        $display("reset: count=%0d valid=%b ready=%b", bus.count, bus.inst_valid, bus.push_ready);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            bus.push_valid = 1'b1;
            bus.pc         = 32'(i * 4);
            bus.mem_rd     = inst_tab[i];
            tick();
            if (i == 0) begin
                checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL fill_first_valid: got %b expected 1", bus.inst_valid); end
            end
        end
        bus.push_valid = 1'b0;
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", bus.count); end
        checks++; if (bus.push_ready !== 1'b0) begin errors++; $display("FAIL fill_push_ready: got %b expected 0", bus.push_ready); end
        checks++; if (bus.pc_old !== 32'h0) begin errors++; $display("FAIL fill_pc_old: got %h expected 0", bus.pc_old); end
        checks++; if (bus.inst !== 32'h13) begin errors++; $display("FAIL fill_inst: got %h expected 00000013", bus.inst); end
        // Push while full with no pop must be ignored.
        bus.push_valid = 1'b1;
        bus.pc         = 32'hDEAD;
        bus.mem_rd     = 32'hDEAD_BEEF;
        tick();
        bus.push_valid = 1'b0;
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_ignore_count: got %0d expected 4", bus.count); end
        checks++; if (bus.pc_old !== 32'h0) begin errors++; $display("FAIL full_ignore_pc_old: got %h expected 0", bus.pc_old); end
        $display("fill: count=%0d head_pc=%h", bus.count, bus.pc_old);
    endtask

    task automatic test_pop_through();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
        bus.inst_ready = 1'b1;
        bus.push_valid = 1'b1;
        bus.pc         = 32'h10;
        bus.mem_rd     = inst_tab[4];
        #1;
        checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL popthru_push_ready: got %b expected 1", bus.push_ready); end
        tick();
        bus.push_valid = 1'b0;
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL popthru_count: got %0d expected 4", bus.count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.pc_old !== exp_pc[i]) begin errors++; $display("FAIL popthru_pc_%0d: got %h expected %h", i, bus.pc_old, exp_pc[i]); end
            checks++; if (bus.inst !== inst_tab[i+1]) begin errors++; $display("FAIL popthru_inst_%0d: got %h expected %h", i, bus.inst, inst_tab[i+1]); end
            $display("pop: pc=%h inst=%h", bus.pc_old, bus.inst);
            tick();
        end
        bus.inst_ready = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL popthru_drained: got %0d expected 0", bus.count); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL popthru_empty_inst: got %h expected 0", bus.inst); end
    endtask

    task automatic test_wrap();
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH + 1; k++) begin
            bus.push_valid = 1'b1;
            bus.pc         = 32'h200 + 32'(4 * k);
            bus.mem_rd     = 32'hA000_0000 + 32'(k);
            tick();
            checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL wrap_count_%0d: got %0d expected 1", k, bus.count); end
            checks++; if (bus.pc_old !== 32'h200 + 32'(4 * k)) begin errors++; $display("FAIL wrap_pc_%0d: got %h expected %h", k, bus.pc_old, 32'h200 + 32'(4 * k)); end
            checks++; if (bus.inst !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL wrap_inst_%0d: got %h expected %h", k, bus.inst, 32'hA000_0000 + 32'(k)); end
            $display("wrap: k=%0d head_pc=%h", k, bus.pc_old);
        end
        bus.push_valid = 1'b0;
        tick();
        bus.inst_ready = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL wrap_drained: got %0d expected 0", bus.count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            bus.push_valid = 1'b1;
            bus.pc         = 32'h300 + 32'(4 * i);
            bus.mem_rd     = 32'hC000_0000 + 32'(i);
            tick();
        end
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", bus.count); end
        bus.flush  = 1'b1;
        bus.pc     = 32'h100;
        bus.mem_rd = 32'h0000_0BAD;
        tick();
        bus.flush      = 1'b0;
        bus.push_valid = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.inst_valid); end
        checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL flush_push_ready: got %b expected 1", bus.push_ready); end
        bus.push_valid = 1'b1;
        bus.pc         = 32'h400;
        bus.mem_rd     = 32'h0400_0013;
        tick();
        bus.push_valid = 1'b0;
        checks++; if (bus.pc_old !== 32'h400) begin errors++; $display("FAIL flush_next_pc: got %h expected 00000400", bus.pc_old); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL flush_next_count: got %0d expected 1", bus.count); end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_final_count: got %0d expected 0", bus.count); end
        $display("flush: count=%0d", bus.count);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            bus.push_valid = 1'b1;
            bus.pc         = 32'h600 + 32'(4 * i);
            bus.mem_rd     = 32'hD000_0000 + 32'(i);
            tick();
        end
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 2", bus.count); end
        rst_n          = 1'b0;
        bus.pc         = 32'h608;
        bus.inst_ready = 1'b1;
        tick();
        rst_n          = 1'b1;
        bus.push_valid = 1'b0;
        bus.inst_ready = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", bus.count); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL rstmid_inst: got %h expected 0", bus.inst); end
        checks++; if (bus.pc_old !== 32'h0) begin errors++; $display("FAIL rstmid_pc_old: got %h expected 0", bus.pc_old); end
        checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL rstmid_push_ready: got %b expected 1", bus.push_ready); end
        $display("reset_mid: count=%0d", bus.count);
    endtask

    task automatic test_empty_push_pop();
        bus.push_valid = 1'b1;
        bus.pc         = 32'h500;
        bus.mem_rd     = 32'h0500_0013;
        bus.inst_ready = 1'b1;
        #1;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL empty_bypass_valid: got %b expected 0", bus.inst_valid); end
        tick();
        bus.push_valid = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL empty_next_valid: got %b expected 1", bus.inst_valid); end
        checks++; if (bus.pc_old !== 32'h500) begin errors++; $display("FAIL empty_next_pc: got %h expected 00000500", bus.pc_old); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL empty_next_count: got %0d expected 1", bus.count); end
        tick();
        bus.inst_ready = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL empty_popped_count: got %0d expected 0", bus.count); end
        $display("empty_push_pop: count=%0d", bus.count);
    endtask

    initial begin
        inst_tab[0] = 32'h0000_0013;
        inst_tab[1] = 32'h0000_0093;
        inst_tab[2] = 32'h0000_0113;
        inst_tab[3] = 32'h0000_0193;
        inst_tab[4] = 32'h0000_0213;
        rst_n          = 1'b0;
        bus.pc         = '0;
        bus.mem_rd     = '0;
        bus.push_valid = 1'b0;
        bus.flush      = 1'b0;
        bus.inst_ready = 1'b0;

        test_reset();
        test_fill();
        test_pop_through();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_empty_push_pop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
